keyboard_move_decoder: RTL and testbench
========================================

KEYBOARD_MOVE_DECODER -- requirements
Module: keyboard_move_decoder

Interface
REQ-001 Parameter PREFIX_TIMEOUT, default 50000, clk cycles a prefix state may wait for the next byte before abandoning the sequence.
REQ-002 Parameter KEY_RIGHT, default 8'h74, extended scan code of the right-move key.
REQ-003 Parameter KEY_LEFT, default 8'h6B, extended scan code of the left-move key.
REQ-004 Parameter KEY_FIRE, default 8'h29, non-extended scan code of the fire key.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  reset, asynchronous, active-low.
REQ-007 din_new  in  1  one-cycle strobe; din is valid in this cycle.
REQ-008 din  in  8  PS/2 set-2 scan-code byte.
REQ-009 RightMove  out  1  level; right-move command to the player-movement block.
REQ-010 LeftMove  out  1  level; left-move command to the player-movement block.
REQ-011 FirePulse  out  1  one-cycle pulse per fire-key press.
REQ-012 seqError  out  1  one-cycle pulse when a prefix sequence times out.

Function
REQ-013 The FSM SHALL have states IDLE, GOT_E0, GOT_F0 and GOT_E0F0, and SHALL advance only in cycles where din_new=1.
REQ-014 In IDLE: 8'hE0 SHALL go to GOT_E0; 8'hF0 SHALL go to GOT_F0; KEY_FIRE SHALL register a fire make; any other byte SHALL stay in IDLE with no effect.
REQ-015 In GOT_E0: 8'hF0 SHALL go to GOT_E0F0; KEY_RIGHT or KEY_LEFT SHALL set the matching held flag and go to IDLE; any other byte SHALL go to IDLE.
REQ-016 In GOT_F0: KEY_FIRE SHALL clear fireHeld; every byte SHALL return the FSM to IDLE.
REQ-017 In GOT_E0F0: KEY_RIGHT or KEY_LEFT SHALL clear the matching held flag; every byte SHALL return the FSM to IDLE.
REQ-018 A fire make SHALL assert FirePulse for exactly one clk, in the cycle after the din_new cycle, and only when fireHeld was 0; it SHALL then set fireHeld, so typematic repeats produce no further pulses.
REQ-019 The block SHALL hold a lastDir register, which is set to RIGHT or LEFT on each make of that key, including repeats.
REQ-020 RightMove SHALL be rightHeld AND (NOT leftHeld OR lastDir=RIGHT); LeftMove SHALL be leftHeld AND (NOT rightHeld OR lastDir=LEFT); both SHALL never be 1 together.
REQ-021 RightMove and LeftMove SHALL be registered and SHALL update one clk after the din_new cycle that changed the held flags.
REQ-022 A counter SHALL increment every clk while the FSM is in a non-IDLE state, and SHALL clear on din_new or on entry to IDLE.
REQ-023 When the counter reaches PREFIX_TIMEOUT-1 with no din_new, the FSM SHALL go to IDLE and pulse seqError for one clk; held flags SHALL be unchanged.
REQ-024 din_new in the same cycle as the timeout SHALL take priority: the byte is decoded and no seqError is generated.
REQ-025 A release byte for a key that is not held SHALL be harmless (the flag stays 0).
REQ-026 The counter width SHALL be $clog2(PREFIX_TIMEOUT)+1, and the counter SHALL not wrap.

Reset
REQ-027 On resetN=0, asynchronously: state=IDLE, the counter, rightHeld, leftHeld, fireHeld, RightMove, LeftMove, FirePulse and seqError SHALL all be 0, and lastDir=RIGHT.
REQ-028 Reset mid-sequence SHALL discard any partial prefix; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-029 The state enum, the constants 8'hE0 and 8'hF0, and the default key codes SHALL live in a shared package kbd_pkg, which the movement and missile blocks also use.
REQ-030 The timeout counter SHALL be a sub-module named prefix_timeout_counter; all other logic SHALL be in a single always_ff plus output registers.

Verification
REQ-031 The bench SHALL drive the bytes E0,74 -> RightMove=1 one clk after the 74 strobe, with LeftMove=0.
REQ-032 The bench SHALL drive E0,74 then E0,6B, then E0,F0,6B -> LeftMove=1 with RightMove=0 while both are held, then RightMove=1 after the left key is released.
REQ-033 The bench SHALL drive 29,29,29 then F0,29 then 29 -> exactly two FirePulses, each one clk wide.
REQ-034 The bench SHALL drive E0 then no strobe for PREFIX_TIMEOUT clks -> one seqError pulse; a following 74 leaves RightMove=0.
REQ-035 The bench SHALL drive E0,74, then assert resetN=0 after E0 of a later E0,F0 -> all outputs are 0 immediately; after release, the bytes F0,74 leave RightMove=0.
REQ-036 The bench SHALL drive F0,74 with nothing held -> no output change and no seqError.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 keyboard definitions: decoder states, prefix bytes and
// default key codes used by the decoder, movement and missile blocks.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } kbd_state_t;

    typedef enum logic {
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;

    localparam logic [7:0] DEFAULT_KEY_RIGHT = 8'h74;
    localparam logic [7:0] DEFAULT_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] DEFAULT_KEY_FIRE  = 8'h29;

    // With both keys held the most recently pressed one wins; returns {right, left}.
    function automatic logic [1:0] resolve_move(input logic right_held,
                                                input logic left_held,
                                                input dir_t last_dir);
        return {right_held && (!left_held || last_dir == DIR_RIGHT),
                left_held  && (!right_held || last_dir == DIR_LEFT)};
    endfunction

endpackage

// File: rtl/prefix_timeout_counter.sv
// Watchdog for a partially received prefix sequence: counts idle cycles while
// the decoder waits for the next byte and flags when the wait is over.
module prefix_timeout_counter #(
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic resetN,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam int CNT_W = $clog2(PREFIX_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a stalled decoder can never see the count wrap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count <= '0;
        else if (clear || !active)
            count <= '0;
        else if (count != LAST)
            count <= count + 1'b1;
    end

    assign timeout = active && (count == LAST);

endmodule

// File: rtl/keyboard_move_decoder.sv
// Decodes PS/2 set-2 scan codes into left/right movement levels, a fire pulse
// and a prefix-timeout error pulse for the player-movement logic.
module keyboard_move_decoder
    import kbd_pkg::*;
#(
    parameter int         PREFIX_TIMEOUT = 50000,
    parameter logic [7:0] KEY_RIGHT      = DEFAULT_KEY_RIGHT,
    parameter logic [7:0] KEY_LEFT       = DEFAULT_KEY_LEFT,
    parameter logic [7:0] KEY_FIRE       = DEFAULT_KEY_FIRE
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       din_new,
    input  logic [7:0] din,
    output logic       RightMove,
    output logic       LeftMove,
    output logic       FirePulse,
    output logic       seqError
);

    kbd_state_t state, state_n;
    dir_t       lastDir, dir_n;
    logic       rightHeld, leftHeld, fireHeld;
    logic       right_n, left_n, fire_n;
    logic       fire_make, seq_err;
    logic [1:0] move_n;
    logic       timeout;

    prefix_timeout_counter #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .resetN (resetN),
        .active (state != IDLE),
        .clear  (din_new || timeout),
        .timeout(timeout)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch.
        state_n   = state;
        right_n   = rightHeld;
        left_n    = leftHeld;
        fire_n    = fireHeld;
        dir_n     = lastDir;
        fire_make = 1'b0;
        seq_err   = 1'b0;

        if (din_new) begin
            unique case (state)
                IDLE: begin
                    if (din == SC_EXTEND)
                        state_n = GOT_E0;
                    else if (din == SC_BREAK)
                        state_n = GOT_F0;
                    else if (din == KEY_FIRE) begin
                        fire_make = !fireHeld;
                        fire_n    = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (din == SC_BREAK)
                        state_n = GOT_E0F0;
                    else begin
                        state_n = IDLE;
                        if (din == KEY_RIGHT) begin
                            right_n = 1'b1;
                            dir_n   = DIR_RIGHT;
                        end else if (din == KEY_LEFT) begin
                            left_n = 1'b1;
                            dir_n  = DIR_LEFT;
                        end
                    end
                end
                GOT_F0: begin
                    state_n = IDLE;
                    if (din == KEY_FIRE)
                        fire_n = 1'b0;
                end
                GOT_E0F0: begin
                    state_n = IDLE;
                    if (din == KEY_RIGHT)
                        right_n = 1'b0;
                    else if (din == KEY_LEFT)
                        left_n = 1'b0;
                end
            endcase
        end else if (timeout) begin
            // Abandon the partial prefix but keep every held key as it was.
            state_n = IDLE;
            seq_err = 1'b1;
        end

        move_n = resolve_move(right_n, left_n, dir_n);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            rightHeld <= 1'b0;
            leftHeld  <= 1'b0;
            fireHeld  <= 1'b0;
            lastDir   <= DIR_RIGHT;
            RightMove <= 1'b0;
            LeftMove  <= 1'b0;
            FirePulse <= 1'b0;
            seqError  <= 1'b0;
        end else begin
            state     <= state_n;
            rightHeld <= right_n;
            leftHeld  <= left_n;
            fireHeld  <= fire_n;
            lastDir   <= dir_n;
            RightMove <= move_n[1];
            LeftMove  <= move_n[0];
            FirePulse <= fire_make;
            seqError  <= seq_err;
        end
    end

endmodule

// File: tb/tb_keyboard_move_decoder.sv
// Scoreboard bench for keyboard_move_decoder: a key-level model predicts output
// events per accepted byte; an independent monitor pops them as the DUT reacts.
module tb_keyboard_move_decoder;

    localparam int         T       = 20;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_FIRE  = 8'h29;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       din_new = 1'b0;
    logic [7:0] din = 8'h00;
    logic       RightMove, LeftMove, FirePulse, seqError;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    keyboard_move_decoder #(
        .PREFIX_TIMEOUT(T),
        .KEY_RIGHT     (K_RIGHT),
        .KEY_LEFT      (K_LEFT),
        .KEY_FIRE      (K_FIRE)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .din_new  (din_new),
        .din      (din),
        .RightMove(RightMove),
        .LeftMove (LeftMove),
        .FirePulse(FirePulse),
        .seqError (seqError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int cyc;
        bit rm;
        bit lm;
        bit fp;
        bit se;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pfx[$];
    bit         m_right, m_left, m_fire, m_recent_left;
    int         age;
    bit         p_rm, p_lm;
    bit         mon_rm, mon_lm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pfx.delete();
        m_right = 0;
        m_left = 0;
        m_fire = 0;
        m_recent_left = 0;
        age = 0;
        p_rm = 0;
        p_lm = 0;
    endtask

    // One clock of the model, for the posedge that samples the current inputs.
    task automatic model_step(input bit nw, input logic [7:0] b);
        bit   fp, se, rm, lm, ext, brk;
        exp_t e;
        fp = 0;
        se = 0;
        if (nw) begin
            age = 0;
            if (pfx.size() == 0) begin
                if (b == 8'hE0 || b == 8'hF0)
                    pfx.push_back(b);
                else if (b == K_FIRE) begin
                    fp = !m_fire;
                    m_fire = 1;
                end
            end else if (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hF0) begin
                pfx.push_back(b);
            end else begin
                ext = (pfx[0] == 8'hE0);
                brk = (pfx[pfx.size()-1] == 8'hF0);
                if (ext && !brk) begin
                    if (b == K_RIGHT) begin m_right = 1; m_recent_left = 0; end
                    else if (b == K_LEFT) begin m_left = 1; m_recent_left = 1; end
                end else if (ext && brk) begin
                    if (b == K_RIGHT) m_right = 0;
                    else if (b == K_LEFT) m_left = 0;
                end else if (b == K_FIRE) begin
                    m_fire = 0;
                end
                pfx.delete();
            end
        end else if (pfx.size() != 0) begin
            age++;
            if (age >= T) begin
                pfx.delete();
                se = 1;
            end
        end
        if (m_right && m_left) begin
            rm = !m_recent_left;
            lm = m_recent_left;
        end else begin
            rm = m_right;
            lm = m_left;
        end
        if (fp || se || rm != p_rm || lm != p_lm) begin
            e.cyc = cyc + 1;
            e.rm = rm;
            e.lm = lm;
            e.fp = fp;
            e.se = se;
            exp_q.push_back(e);
        end
        p_rm = rm;
        p_lm = lm;
    endtask

    task automatic cyc_step(input bit nw, input logic [7:0] b);
        @(negedge clk);
        din_new = nw;
        din = b;
        model_step(nw, b);
    endtask

    task automatic send(input logic [7:0] b);
        cyc_step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc_step(1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 check("reset_outputs", {28'd0, RightMove, LeftMove, FirePulse, seqError}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;
    endtask

    // Monitor: any pulse or movement-level change is a DUT output event.
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            mon_rm = 0;
            mon_lm = 0;
        end else if (FirePulse || seqError || RightMove != mon_rm || LeftMove != mon_lm) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output at cycle %0d: got R=%0b L=%0b fire=%0b err=%0b, expected no event",
                         cyc, RightMove, LeftMove, FirePulse, seqError);
            end else begin
                e = exp_q.pop_front();
                check("output_event",
                      {cyc[27:0], RightMove, LeftMove, FirePulse, seqError},
                      {e.cyc[27:0], e.rm, e.lm, e.fp, e.se});
            end
            mon_rm = RightMove;
            mon_lm = LeftMove;
        end
    end

    initial begin
        logic [7:0] b;
        model_reset();
        #1 resetN = 1'b0;
        #1 check("reset_state", {28'd0, RightMove, LeftMove, FirePulse, seqError}, 32'd0);
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;

        // Right key make, then release.
        send(8'hE0); idle(1); send(K_RIGHT); idle(2);
        send(8'hE0); send(8'hF0); send(K_RIGHT); idle(2);

        // Both held: latest wins; releasing left hands control back to right.
        send(8'hE0); send(K_RIGHT); idle(2);
        send(8'hE0); send(K_LEFT); idle(2);
        send(8'hE0); send(8'hF0); send(K_LEFT); idle(2);
        send(8'hE0); send(8'hF0); send(K_RIGHT); idle(2);

        // Fire with typematic repeats, release, press again.
        send(K_FIRE); idle(1); send(K_FIRE); idle(1); send(K_FIRE); idle(1);
        send(8'hF0); send(K_FIRE); idle(1); send(K_FIRE); idle(2);
        send(8'hF0); send(K_FIRE); idle(2);

        // Prefix timeout; the stray key code afterwards is ignored.
        send(8'hE0); idle(T + 2); send(K_RIGHT); idle(2);

        // Byte arriving exactly at the timeout cycle wins over the timeout.
        send(8'hE0); idle(T - 1); send(K_RIGHT); idle(2);
        send(8'hE0); idle(T - 2); send(8'hF0); idle(T - 1); send(K_RIGHT); idle(2);

        // Reset in the middle of a release prefix while right is held.
        send(8'hE0); send(K_RIGHT); idle(2);
        send(8'hE0); idle(1);
        do_reset();
        send(8'hF0); send(K_RIGHT); idle(3);

        // Release of a key that is not held.
        send(8'hF0); send(K_RIGHT); idle(2);
        send(8'hE0); send(8'hF0); send(K_LEFT); idle(2);

        // Randomised byte stream with gaps around the timeout boundary.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0, 1: b = 8'hE0;
                2:    b = 8'hF0;
                3:    b = K_RIGHT;
                4:    b = K_LEFT;
                5:    b = K_FIRE;
                default: b = 8'($urandom);
            endcase
            send(b);
            if ($urandom_range(0, 9) == 0)
                idle($urandom_range(T - 2, T + 2));
            else
                idle($urandom_range(0, 3));
        end

        idle(T + 5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
